alu_mdu: RTL and testbench

Parametrised successor to the single-cycle ALU for the MIPS core: full MIPS-I integer ALU operation set with signed-overflow detection, plus an iterative multiply/divide unit owning the HI/LO registers. Sits in the execute stage. Single-cycle ops return combinationally. MULT/MULTU/DIV/DIVU run for WIDTH+1 cycles behind a ready/valid handshake, which the pipeline uses to stall.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/muldiv_iter.sv | 145 ++++++++++++++
 rtl/alu_mdu.sv | 85 ++++++++
 tb/tb_alu_mdu.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared operation encoding, multiply/divide FSM states and
// a helper identifying operations handled by the iterative unit.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'd0,
        ALU_ADDU  = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SUBU  = 5'd3,
        ALU_AND   = 5'd4,
        ALU_OR    = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_NOR   = 5'd7,
        ALU_SLT   = 5'd8,
        ALU_SLTU  = 5'd9,
        ALU_SLL   = 5'd10,
        ALU_SRL   = 5'd11,
        ALU_SRA   = 5'd12,
        ALU_SLLV  = 5'd13,
        ALU_SRLV  = 5'd14,
        ALU_SRAV  = 5'd15,
        ALU_LUI   = 5'd16,
        ALU_MFHI  = 5'd17,
        ALU_MFLO  = 5'd18,
        ALU_MTHI  = 5'd19,
        ALU_MTLO  = 5'd20,
        ALU_MULT  = 5'd21,
        ALU_MULTU = 5'd22,
        ALU_DIV   = 5'd23,
        ALU_DIVU  = 5'd24
    } alu_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_FIX
    } md_state_t;

    function automatic logic is_md_op(alu_op_t op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply / restoring divide owning HI/LO.
// Ports: clk, rst (async high), valid/op/arg1/arg2 request, ready, hi, lo.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] arg1,
    input  logic [WIDTH-1:0] arg2,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic neg_q, neg_d;
    logic rneg_q, rneg_d;
    logic div_q, div_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic op_signed, op_div;
    logic sgn1, sgn2;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0] madd, dsub;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    assign op_signed = (op == ALU_MULT) || (op == ALU_DIV);
    assign op_div    = (op == ALU_DIV) || (op == ALU_DIVU);
    assign sgn1 = op_signed & arg1[WIDTH-1];
    assign sgn2 = op_signed & arg2[WIDTH-1];
    assign abs1 = sgn1 ? -arg1 : arg1;
    assign abs2 = sgn2 ? -arg2 : arg2;

    // Multiply: p = {partial, multiplier}; add multiplicand on LSB, shift right.
    assign madd = {1'b0, p_q[2*WIDTH-1:WIDTH]} +
                  (p_q[0] ? {1'b0, a_q} : '0);
    // Divide: p = {remainder, dividend}; trial-subtract shifted remainder.
    assign dsub = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]} - {1'b0, a_q};

    assign prod = neg_q ? -p_q : p_q;
    assign quo  = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    assign rem  = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        p_d     = p_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (valid && is_md_op(op)) begin
                    state_d = op_div ? MD_DIV : MD_MUL;
                    cnt_d   = '0;
                    div_d   = op_div;
                    a_d     = op_div ? abs2 : abs1;
                    p_d     = {{WIDTH{1'b0}}, op_div ? abs1 : abs2};
                    // Divide by zero keeps the raw all-ones quotient.
                    neg_d   = (sgn1 ^ sgn2) && !(op_div && arg2 == '0);
                    rneg_d  = op_div && sgn1;
                end else if (valid && op == ALU_MTHI) begin
                    hi_d = arg1;
                end else if (valid && op == ALU_MTLO) begin
                    lo_d = arg1;
                end
            end
            MD_MUL: begin
                p_d   = {madd, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = MD_FIX;
                    cnt_d   = '0;
                end
            end
            MD_DIV: begin
                if (!dsub[WIDTH]) begin
                    p_d = {dsub[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = {p_q[2*WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = MD_FIX;
                    cnt_d   = '0;
                end
            end
            MD_FIX: begin
                if (div_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign ready = (state_q == MD_IDLE);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: MIPS-I execute-stage ALU with overflow detect and HI/LO access.
// Ports: clk, rst, ctrl, arg1, arg2, shamt, valid -> ready, result, zero, overflow, hi, lo.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  alu_op_t            ctrl,
    input  logic [WIDTH-1:0]   arg1,
    input  logic [WIDTH-1:0]   arg2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               valid,
    output logic               ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               overflow,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    logic [WIDTH-1:0] sum, diff;
    logic [SHAMT_W-1:0] vsh;
    logic s1, s2;

    assign sum  = arg1 + arg2;
    assign diff = arg1 - arg2;
    assign vsh  = arg1[SHAMT_W-1:0];
    assign s1   = arg1[WIDTH-1];
    assign s2   = arg2[WIDTH-1];
    assign zero = (arg1 == arg2);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (ctrl)
            ALU_ADD: begin
                result   = sum;
                overflow = (s1 == s2) && (sum[WIDTH-1] != s1);
            end
            ALU_ADDU: result = sum;
            ALU_SUB: begin
                result   = diff;
                overflow = (s1 != s2) && (diff[WIDTH-1] != s1);
            end
            ALU_SUBU: result = diff;
            ALU_AND:  result = arg1 & arg2;
            ALU_OR:   result = arg1 | arg2;
            ALU_XOR:  result = arg1 ^ arg2;
            ALU_NOR:  result = ~(arg1 | arg2);
            ALU_SLT:
                result = {{(WIDTH-1){1'b0}},
                          $signed(arg1) < $signed(arg2)};
            ALU_SLTU:
                result = {{(WIDTH-1){1'b0}}, arg1 < arg2};
            ALU_SLL:  result = arg2 << shamt;
            ALU_SRL:  result = arg2 >> shamt;
            ALU_SRA:  result = $signed(arg2) >>> shamt;
            ALU_SLLV: result = arg2 << vsh;
            ALU_SRLV: result = arg2 >> vsh;
            ALU_SRAV: result = $signed(arg2) >>> vsh;
            ALU_LUI:  result = arg2 << (WIDTH / 2);
            ALU_MFHI: result = hi;
            ALU_MFLO: result = lo;
            default:  result = '0;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_md (
        .clk  (clk),
        .rst  (rst),
        .valid(valid),
        .op   (ctrl),
        .arg1 (arg1),
        .arg2 (arg2),
        .ready(ready),
        .hi   (hi),
        .lo   (lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for alu_mdu; stimulus queues expectations,
// a negedge monitor pops and compares them against DUT outputs.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    alu_op_t     ctrl;
    logic [31:0] arg1, arg2;
    logic [4:0]  shamt;
    logic        valid;
    logic        ready;
    logic [31:0] result;
    logic        zero, overflow;
    logic [31:0] hi, lo;

    alu_mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl    (ctrl),
        .arg1    (arg1),
        .arg2    (arg2),
        .shamt   (shamt),
        .valid   (valid),
        .ready   (ready),
        .result  (result),
        .zero    (zero),
        .overflow(overflow),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    typedef enum {K_COMB, K_STATE, K_MD} kind_t;
    typedef struct {
        string       nm;
        kind_t       kind;
        logic [31:0] r;
        logic        o;
        logic        z;
        logic        rdy;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t q[$];
    int n_chk  = 0;
    int n_pass = 0;
    int busy   = 0;
    int wt     = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, want);
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        $display("FAIL %s timeout", nm);
    endtask

    // Monitor: multiply/divide items complete on the ready rising edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].kind == K_MD) begin
                e = q[0];
                if (!ready) busy++;
                else if (busy == 0) wt++;
                if (ready && busy > 0) begin
                    chk({e.nm, ".hi"}, hi, e.h);
                    chk({e.nm, ".lo"}, lo, e.l);
                    chk({e.nm, ".busy"}, busy, 33);
                    void'(q.pop_front());
                    busy = 0;
                    wt   = 0;
                end else if (wt > 8 || busy > 200) begin
                    tmo(e.nm);
                    void'(q.pop_front());
                    busy = 0;
                    wt   = 0;
                end
            end
            while (q.size() > 0 && q[0].kind != K_MD) begin
                e = q.pop_front();
                if (e.kind == K_COMB) begin
                    chk({e.nm, ".res"}, result, e.r);
                    chk({e.nm, ".ovf"}, {31'b0, overflow}, {31'b0, e.o});
                    chk({e.nm, ".zero"}, {31'b0, zero}, {31'b0, e.z});
                end else begin
                    chk({e.nm, ".rdy"}, {31'b0, ready}, {31'b0, e.rdy});
                    chk({e.nm, ".hi"}, hi, e.h);
                    chk({e.nm, ".lo"}, lo, e.l);
                end
            end
        end
    end

    task automatic push_comb(input string nm, input logic [31:0] r,
                             input logic o);
        exp_t e;
        e.nm = nm; e.kind = K_COMB; e.r = r; e.o = o;
        e.z = (arg1 == arg2); e.rdy = 1'b1; e.h = '0; e.l = '0;
        q.push_back(e);
    endtask

    task automatic push_st(input string nm, input logic rdy,
                           input logic [31:0] h, input logic [31:0] l);
        exp_t e;
        e.nm = nm; e.kind = K_STATE; e.r = '0; e.o = 1'b0;
        e.z = 1'b0; e.rdy = rdy; e.h = h; e.l = l;
        q.push_back(e);
    endtask

    task automatic push_md(input string nm, input logic [31:0] h,
                           input logic [31:0] l);
        exp_t e;
        e.nm = nm; e.kind = K_MD; e.r = '0; e.o = 1'b0;
        e.z = 1'b0; e.rdy = 1'b1; e.h = h; e.l = l;
        q.push_back(e);
    endtask

    task automatic wait_ready(input int max);
        int n = 0;
        while (!ready && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) tmo("wait_ready");
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tmo("drain");
            q.delete();
        end
    endtask

    task automatic comb(input string nm, input alu_op_t op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [31:0] r,
                        input logic o);
        @(posedge clk); #1;
        ctrl = op; arg1 = a; arg2 = b; shamt = sh; valid = 1'b0;
        push_comb(nm, r, o);
    endtask

    task automatic md(input string nm, input alu_op_t op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] h, input logic [31:0] l);
        @(posedge clk); #1;
        wait_ready(100);
        ctrl = op; arg1 = a; arg2 = b; valid = 1'b1;
        push_md(nm, h, l);
        @(posedge clk); #1;
        valid = 1'b0; ctrl = ALU_ADD;
        wait_drain(100);
    endtask

    task automatic mt(input string nm, input alu_op_t op,
                      input logic [31:0] a, input logic [31:0] h,
                      input logic [31:0] l);
        @(posedge clk); #1;
        ctrl = op; arg1 = a; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; ctrl = ALU_ADD;
        push_st(nm, 1'b1, h, l);
    endtask

    initial begin : stim
        rst = 1'b1; ctrl = ALU_ADD; arg1 = '0; arg2 = '0;
        shamt = '0; valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        push_st("reset", 1'b1, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        comb("add_ovf", ALU_ADD, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 1);
        comb("addu", ALU_ADDU, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0);
        comb("sub_ovf", ALU_SUB, 32'h80000000, 32'h1, 0, 32'h7FFFFFFF, 1);
        comb("add_neg", ALU_ADD, 32'h80000000, 32'h80000000, 0, 32'h0, 1);
        comb("add_ok", ALU_ADD, 32'hFFFFFFFF, 32'h2, 0, 32'h1, 0);
        comb("subu", ALU_SUBU, 32'h5, 32'h5, 0, 32'h0, 0);
        comb("and", ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h00F000F0, 0);
        comb("or", ALU_OR, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFFF0FFF0, 0);
        comb("xor", ALU_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'hFF00FF00, 0);
        comb("nor", ALU_NOR, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 32'h000F000F, 0);
        comb("slt", ALU_SLT, 32'hFFFFFFFF, 32'h1, 0, 32'h1, 0);
        comb("sltu", ALU_SLTU, 32'hFFFFFFFF, 32'h1, 0, 32'h0, 0);
        comb("sll", ALU_SLL, 32'h0, 32'h80000001, 1, 32'h00000002, 0);
        comb("srl", ALU_SRL, 32'h0, 32'h80000000, 31, 32'h00000001, 0);
        comb("sra", ALU_SRA, 32'h0, 32'h80000000, 4, 32'hF8000000, 0);
        comb("sllv", ALU_SLLV, 32'h24, 32'h1, 0, 32'h00000010, 0);
        comb("srlv", ALU_SRLV, 32'h8, 32'h80000000, 0, 32'h00800000, 0);
        comb("srav", ALU_SRAV, 32'h1, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, 0);
        comb("lui", ALU_LUI, 32'h0, 32'h1234, 0, 32'h12340000, 0);
        comb("undef", alu_op_t'(5'd31), 32'h7FFFFFFF, 32'h1, 0, 32'h0, 0);

        md("mult", ALU_MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        comb("mfhi", ALU_MFHI, 32'h0, 32'h0, 0, 32'hFFFFFFFF, 0);
        comb("mflo", ALU_MFLO, 32'h0, 32'h0, 0, 32'hFFFFFFF1, 0);
        md("multu", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001);
        md("div", ALU_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md("divu0", ALU_DIVU, 32'h7, 32'h0, 32'h00000007, 32'hFFFFFFFF);
        md("divs0", ALU_DIV, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        md("divmin", ALU_DIV, 32'h80000000, 32'hFFFFFFFF,
           32'h0, 32'h80000000);

        // Held MFLO stall with an ignored MULT presented mid-operation.
        @(posedge clk); #1;
        ctrl = ALU_MULTU; arg1 = 32'd6; arg2 = 32'd7; valid = 1'b1;
        push_md("stall", 32'h0, 32'd42);
        @(posedge clk); #1;
        ctrl = ALU_MFLO; arg1 = 32'h0; arg2 = 32'h1;
        repeat (9) @(posedge clk); #1;
        ctrl = ALU_MULT; arg1 = 32'd100; arg2 = 32'd100;
        @(posedge clk); #1;
        ctrl = ALU_MFLO; arg1 = 32'h0; arg2 = 32'h1;
        wait_ready(100);
        push_comb("mflo42", 32'd42, 1'b0);
        @(posedge clk); #1;
        valid = 1'b0; ctrl = ALU_ADD;
        wait_drain(100);

        // Back-to-back: second request in the first ready cycle.
        @(posedge clk); #1;
        ctrl = ALU_MULTU; arg1 = 32'd3; arg2 = 32'd5; valid = 1'b1;
        push_md("b2b_mul", 32'h0, 32'd15);
        @(posedge clk); #1;
        valid = 1'b0;
        wait_ready(100);
        ctrl = ALU_DIVU; arg1 = 32'd100; arg2 = 32'd7; valid = 1'b1;
        push_md("b2b_div", 32'd2, 32'd14);
        @(posedge clk); #1;
        valid = 1'b0; ctrl = ALU_ADD;
        wait_drain(200);

        mt("mthi", ALU_MTHI, 32'h11111111, 32'h11111111, 32'd14);
        mt("mtlo", ALU_MTLO, 32'h22222222, 32'h11111111, 32'h22222222);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        ctrl = ALU_DIVU; arg1 = 32'd100; arg2 = 32'd7; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0; ctrl = ALU_ADD;
        repeat (4) @(posedge clk); #1;
        push_st("hold", 1'b0, 32'h11111111, 32'h22222222);
        repeat (5) @(posedge clk); #3;
        rst = 1'b1;
        push_st("abort", 1'b1, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        md("after", ALU_MULTU, 32'd3, 32'd4, 32'h0, 32'd12);

        wait_drain(100);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
